// File: rtl/vga_frame_rd_sched_if.sv
// Handshake bundle between the frame read scheduler, the SDRAM arbiter read port and the display FIFO.
// With VGA_RD_PINGPONG_EN defined the bundle also carries the writer's frame-done strobe and the read bank.
interface vga_frame_rd_sched_if #(
   parameter int ADDR_W = 22,
   parameter int LVL_W  = 11
);
   logic              frame_start;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_clr;
   logic              rd_req;
   logic              rd_ack;
   logic [ADDR_W-1:0] rd_addr;
   logic [8:0]        rd_len;
   logic              rd_done;
   logic              frame_done;
   logic              busy;
`ifdef VGA_RD_PINGPONG_EN
   logic              wr_frame_done;
   logic              rd_bank;

   modport master (
      input  frame_start, fifo_level, rd_ack, rd_done, wr_frame_done,
      output fifo_clr, rd_req, rd_addr, rd_len, frame_done, busy, rd_bank
   );
   modport slave (
      output frame_start, fifo_level, rd_ack, rd_done, wr_frame_done,
      input  fifo_clr, rd_req, rd_addr, rd_len, frame_done, busy, rd_bank
   );
`else
   modport master (
      input  frame_start, fifo_level, rd_ack, rd_done,
      output fifo_clr, rd_req, rd_addr, rd_len, frame_done, busy
   );
   modport slave (
      output frame_start, fifo_level, rd_ack, rd_done,
      input  fifo_clr, rd_req, rd_addr, rd_len, frame_done, busy
   );
`endif
endinterface

// File: rtl/vga_frame_rd_sched.sv
// Schedules fixed-length SDRAM read bursts that keep the VGA pixel FIFO topped up, restarting at each frame.
// Optional macro VGA_RD_PINGPONG_EN selects between two frame buffer banks fed by a camera writer.
module vga_frame_rd_sched #(
   parameter int          ADDR_W      = 22,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned BANK_STRIDE = 32'h0010_0000,
   parameter int unsigned FRAME_WORDS = 737280,
   parameter int unsigned BURST_LEN   = 256,
   parameter int unsigned FIFO_DEPTH  = 1024,
   parameter int unsigned FIFO_LOW    = 512,
   parameter int          LVL_W       = 11
) (
   input logic               sclk,
   input logic               s_rst,
   vga_frame_rd_sched_if.master bus
);
   // Never ask for more than the FIFO has room for once it dips below the threshold.
   localparam int unsigned BURST_MAX = (BURST_LEN < FIFO_DEPTH - FIFO_LOW) ? BURST_LEN
                                                                         : FIFO_DEPTH - FIFO_LOW;
   localparam logic [19:0]       BURST_W   = 20'(BURST_MAX);
   localparam logic [ADDR_W-1:0] BANK0     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] BANK1     = ADDR_W'(BASE_ADDR + BANK_STRIDE);
   localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(FIFO_LOW);

   typedef enum logic [2:0] {IDLE, FLUSH, FILL, REQ, BURST} state_t;

   state_t            state_reg;
   logic [19:0]       remaining_reg;
   logic              restart_pend_reg;
   logic              fifo_clr_reg;
   logic              rd_req_reg;
   logic              frame_done_reg;
   logic              busy_reg;
   logic [ADDR_W-1:0] rd_addr_reg;
   logic [8:0]        rd_len_reg;
   logic              bank_sel;
   logic [ADDR_W-1:0] frame_base;
   logic              ack_accept;

`ifdef VGA_RD_PINGPONG_EN
   logic wr_bank_reg;
   logic wr_next_reg;
   logic rd_bank_reg;

   // wr_next_reg is the bank the writer is filling; wr_bank_reg the one it finished last.
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         wr_bank_reg <= 1'b0;
         wr_next_reg <= 1'b0;
         rd_bank_reg <= 1'b0;
      end else begin
         if (bus.wr_frame_done) begin
            wr_bank_reg <= wr_next_reg;
            wr_next_reg <= ~wr_next_reg;
         end
         if (state_reg == FLUSH) begin
            rd_bank_reg <= wr_bank_reg;
         end
      end
   end

   assign bank_sel    = wr_bank_reg;
   assign bus.rd_bank = rd_bank_reg;
`else
   assign bank_sel = 1'b0;
`endif

   assign frame_base = bank_sel ? BANK1 : BANK0;
   assign ack_accept = bus.rd_ack && rd_req_reg;

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state_reg        <= IDLE;
         remaining_reg    <= '0;
         restart_pend_reg <= 1'b0;
         fifo_clr_reg     <= 1'b0;
         rd_req_reg       <= 1'b0;
         frame_done_reg   <= 1'b0;
         busy_reg         <= 1'b0;
         rd_addr_reg      <= BANK0;
         rd_len_reg       <= '0;
      end else begin
         fifo_clr_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.frame_start) begin
                  state_reg    <= FLUSH;
                  fifo_clr_reg <= 1'b1;
               end
            end
            FLUSH: begin
               remaining_reg <= 20'(FRAME_WORDS);
               rd_addr_reg   <= frame_base;
               state_reg     <= FILL;
            end
            FILL: begin
               if (bus.frame_start) begin
                  state_reg    <= FLUSH;
                  fifo_clr_reg <= 1'b1;
               end else if (remaining_reg == '0) begin
                  state_reg <= IDLE;
               end else if (bus.fifo_level < LOW_LVL) begin
                  rd_len_reg <= (remaining_reg < BURST_W) ? remaining_reg[8:0] : BURST_W[8:0];
                  state_reg  <= REQ;
                  busy_reg   <= 1'b1;
               end
            end
            REQ: begin
               if (ack_accept) begin
                  rd_req_reg <= 1'b0;
                  state_reg  <= BURST;
                  if (bus.frame_start) begin
                     restart_pend_reg <= 1'b1;
                  end
               end else if (bus.frame_start) begin
                  // Not yet accepted, so the request can simply be withdrawn.
                  rd_req_reg   <= 1'b0;
                  busy_reg     <= 1'b0;
                  state_reg    <= FLUSH;
                  fifo_clr_reg <= 1'b1;
               end else begin
                  rd_req_reg <= 1'b1;
               end
            end
            BURST: begin
               if (bus.rd_done) begin
                  rd_addr_reg    <= rd_addr_reg + ADDR_W'(rd_len_reg);
                  remaining_reg  <= remaining_reg - 20'(rd_len_reg);
                  frame_done_reg <= (remaining_reg == 20'(rd_len_reg));
                  busy_reg       <= 1'b0;
                  if (restart_pend_reg || bus.frame_start) begin
                     state_reg        <= FLUSH;
                     fifo_clr_reg     <= 1'b1;
                     restart_pend_reg <= 1'b0;
                  end else begin
                     state_reg <= FILL;
                  end
               end else if (bus.frame_start) begin
                  restart_pend_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               rd_req_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_clr   = fifo_clr_reg;
   assign bus.rd_req     = rd_req_reg;
   assign bus.rd_addr    = rd_addr_reg;
   assign bus.rd_len     = rd_len_reg;
   assign bus.frame_done = frame_done_reg;
   assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Scoreboard bench for vga_frame_rd_sched: directed frames with a small arbiter model, monitor checks events in order.
// Build with VGA_RD_PINGPONG_EN defined to also exercise bank selection.
module tb_vga_frame_rd_sched;
   logic sclk = 1'b0;
   logic s_rst = 1'b1;

   vga_frame_rd_sched_if #(.ADDR_W(22), .LVL_W(11)) rif ();

   vga_frame_rd_sched #(
      .ADDR_W(22), .BASE_ADDR(0), .BANK_STRIDE(32'h0010_0000), .FRAME_WORDS(600),
      .BURST_LEN(256), .FIFO_DEPTH(1024), .FIFO_LOW(512), .LVL_W(11)
   ) dut (
      .sclk (sclk),
      .s_rst(s_rst),
      .bus  (rif)
   );

   always #5 sclk = ~sclk;

   localparam int K_CLR = 0, K_REQ = 1, K_DONE = 2;
   typedef struct {
      int          kind;
      logic [21:0] addr;
      logic [8:0]  len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   req_count = 0;
   int   ack_delay = 0;
   int   done_delay = 3;
   bit   burst_open = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push(input int kind, input logic [21:0] addr, input logic [8:0] len);
      exp_t e;
      e.kind = kind; e.addr = addr; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [21:0] base);
      push(K_CLR, 0, 0);
      push(K_REQ, base, 9'd256);
      push(K_REQ, base + 22'd256, 9'd256);
      push(K_REQ, base + 22'd512, 9'd88);
      push(K_DONE, 0, 0);
   endtask

   task automatic sb_pop(input int kind, input logic [21:0] addr, input logic [8:0] len);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d addr=%0h len=%0d expected none", kind, addr, len);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == K_REQ && (e.addr != addr || e.len != len))) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%0h len=%0d expected kind=%0d addr=%0h len=%0d",
                     kind, addr, len, e.kind, e.addr, e.len);
         end else begin
            $display("[%0t] event kind=%0d addr=%0h len=%0d ok", $time, kind, addr, len);
         end
      end
   endtask

   // Monitor: compares every DUT event against the scoreboard and checks request stability.
   bit          prev_req = 0, prev_ack = 0, prev_done = 0;
   logic [21:0] hold_addr;
   logic [8:0]  hold_len;
   int          hold_cycles = 0;
   always @(negedge sclk) begin
      if (!s_rst) begin
         if (rif.frame_done) begin
            sb_pop(K_DONE, 0, 0);
            chk("frame_done_after_rd_done", 32'(prev_done), 1);
         end
         if (rif.fifo_clr) begin
            sb_pop(K_CLR, 0, 0);
            chk("clr_during_burst", 32'(burst_open), 0);
         end
         if (prev_ack) chk("req_drop_after_ack", 32'(rif.rd_req), 0);
         if (rif.rd_req && !prev_req) begin
            sb_pop(K_REQ, rif.rd_addr, rif.rd_len);
            req_count++;
            hold_addr = rif.rd_addr;
            hold_len = rif.rd_len;
            hold_cycles = 0;
         end
         if (rif.rd_req) begin
            hold_cycles++;
            if (prev_req) begin
               chk("req_addr_stable", 32'(rif.rd_addr), 32'(hold_addr));
               chk("req_len_stable", 32'(rif.rd_len), 32'(hold_len));
            end
            if (rif.rd_ack) chk("req_hold_cycles", 32'(hold_cycles), 32'(ack_delay + 1));
         end
         prev_ack  = rif.rd_ack && rif.rd_req;
         prev_req  = rif.rd_req;
         prev_done = rif.rd_done;
      end
   end

   // Arbiter model: acks after ack_delay cycles unless withdrawn, then completes after done_delay.
   initial begin
      int  n;
      bit  withdrawn;
      rif.rd_ack = 1'b0;
      rif.rd_done = 1'b0;
      forever begin
         @(posedge sclk); #1;
         if (!s_rst && rif.rd_req) begin
            n = 0;
            withdrawn = 0;
            while (n < ack_delay) begin
               @(posedge sclk); #1;
               if (!rif.rd_req) begin
                  withdrawn = 1;
                  break;
               end
               n++;
            end
            if (!withdrawn) begin
               rif.rd_ack = 1'b1;
               burst_open = 1;
               @(posedge sclk); #1;
               rif.rd_ack = 1'b0;
               repeat (done_delay) begin @(posedge sclk); #1; end
               rif.rd_done = 1'b1;
               @(posedge sclk); #1;
               rif.rd_done = 1'b0;
               burst_open = 0;
            end
         end
      end
   end

   task automatic pulse_fs();
      rif.frame_start = 1'b1;
      @(posedge sclk); #1;
      rif.frame_start = 1'b0;
   endtask

   task automatic wait_req(input int target);
      for (int i = 0; i < 300; i++) begin
         @(negedge sclk); #1;
         if (req_count >= target) return;
      end
      chk("wait_req_timeout", 32'(req_count), 32'(target));
   endtask

   task automatic drain(input string name);
      repeat (150) @(posedge sclk);
      #1;
      chk({name, "_sb_drained"}, 32'(exp_q.size()), 0);
      chk({name, "_idle"}, 32'(rif.busy), 0);
   endtask

`ifdef VGA_RD_PINGPONG_EN
   task automatic pulse_wr();
      rif.wr_frame_done = 1'b1;
      @(posedge sclk); #1;
      rif.wr_frame_done = 1'b0;
   endtask
`endif

   initial begin
      rif.frame_start = 1'b0;
      rif.fifo_level = '0;
`ifdef VGA_RD_PINGPONG_EN
      rif.wr_frame_done = 1'b0;
`endif
      repeat (3) @(posedge sclk);
      #1;
      chk("rst_fifo_clr", 32'(rif.fifo_clr), 0);
      chk("rst_rd_req", 32'(rif.rd_req), 0);
      chk("rst_frame_done", 32'(rif.frame_done), 0);
      chk("rst_busy", 32'(rif.busy), 0);
      chk("rst_rd_addr", 32'(rif.rd_addr), 0);
      chk("rst_rd_len", 32'(rif.rd_len), 0);
      s_rst = 1'b0;
      @(posedge sclk); #1;

      // Full frame, FIFO always empty.
      ack_delay = 0; done_delay = 3;
      push_frame(22'd0);
      pulse_fs();
      drain("frame_basic");
      chk("end_rd_addr", 32'(rif.rd_addr), 600);

      // Threshold: 700 and 512 hold off, 511 requests two cycles later.
      rif.fifo_level = 11'd700;
      push(K_CLR, 0, 0);
      pulse_fs();
      repeat (10) @(posedge sclk);
      rif.fifo_level = 11'd512;
      repeat (10) @(posedge sclk);
      #1;
      chk("no_req_level_high", 32'(exp_q.size()), 0);
      chk("no_req_rd_req", 32'(rif.rd_req), 0);
      push(K_REQ, 22'd0, 9'd256);
      push(K_REQ, 22'd256, 9'd256);
      push(K_REQ, 22'd512, 9'd88);
      push(K_DONE, 0, 0);
      @(posedge sclk); #1;
      rif.fifo_level = 11'd511;
      @(posedge sclk); #1;
      chk("latency_cycle1", 32'(rif.rd_req), 0);
      @(posedge sclk); #1;
      chk("latency_cycle2", 32'(rif.rd_req), 1);
      drain("threshold");
      rif.fifo_level = '0;

      // Slow arbiter: request held stable across a 10-cycle ack delay.
      ack_delay = 10;
      push_frame(22'd0);
      pulse_fs();
      drain("slow_ack");

      // Restart during the second burst waits for rd_done.
      ack_delay = 0; done_delay = 8;
      push(K_CLR, 0, 0);
      push(K_REQ, 22'd0, 9'd256);
      push(K_REQ, 22'd256, 9'd256);
      push_frame(22'd0);
      pulse_fs();
      wait_req(req_count + 2);
      repeat (2) @(posedge sclk);
      #1;
      pulse_fs();
      drain("restart_burst");

      // Restart during an un-acked request withdraws it.
      ack_delay = 6; done_delay = 3;
      push(K_CLR, 0, 0);
      push(K_REQ, 22'd0, 9'd256);
      push_frame(22'd0);
      pulse_fs();
      wait_req(req_count + 1);
      rif.frame_start = 1'b1;
      @(posedge sclk); #1;
      rif.frame_start = 1'b0;
      chk("withdraw_rd_req", 32'(rif.rd_req), 0);
      drain("restart_req");

`ifdef VGA_RD_PINGPONG_EN
      ack_delay = 0; done_delay = 3;
      pulse_wr();
      pulse_wr();
      push_frame(22'h100000);
      pulse_fs();
      wait_req(req_count + 1);
      chk("rd_bank_frame", 32'(rif.rd_bank), 1);
      pulse_wr();
      drain("pingpong_bank1");
      chk("rd_bank_hold", 32'(rif.rd_bank), 1);
      push_frame(22'd0);
      pulse_fs();
      drain("pingpong_bank0");
      chk("rd_bank_next", 32'(rif.rd_bank), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
